// File: rtl/an_sec_decoder_iter.sv
// an_sec_decoder_iter: iterative single-error-correcting decoder for AN codes.
// The codeword is divided by A with a serial restoring divider. A nonzero remainder
// launches a search that steps p = 2^k mod A and compares it against r (e = +2^k)
// and A-r (e = -2^k). A hit corrects the codeword, which is then divided again.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both
// high; out_valid with N and all flags holds steady until out_ready is seen.
// Optional macro AN_SEC_STATS_EN adds saturating corr_cnt / uncorr_cnt counters.
module an_sec_decoder_iter #(
    parameter int A        = 83,
    parameter int W_BITS   = 36,
    parameter int A_BITS   = 7,
    parameter int N_BITS   = 29,
    parameter int LOC_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W_BITS-1:0]   W,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   N,
    output logic                corrected,
    output logic                uncorrectable,
    output logic                err_neg,
    output logic [LOC_BITS-1:0] err_loc
`ifdef AN_SEC_STATS_EN
    ,
    output logic [15:0]         corr_cnt,
    output logic [15:0]         uncorr_cnt
`endif
);

    localparam int CNT_BITS = $clog2(W_BITS + 1);
    localparam logic [A_BITS:0]     A_EXT    = (A_BITS + 1)'(A);
    localparam logic [A_BITS-1:0]   A_VAL    = A_BITS'(A);
    localparam logic [W_BITS:0]     ONE_W    = (W_BITS + 1)'(1);
    localparam logic [LOC_BITS-1:0] K_LAST   = LOC_BITS'(W_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(W_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_CHK,
        S_SRCH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [W_BITS-1:0]   w_reg;    // codeword (corrected in place on a search hit)
    logic [W_BITS-1:0]   d_reg;    // dividend shifts out MSB first, quotient shifts in
    logic [A_BITS-1:0]   rem;      // remainder r after the last divide step
    logic [CNT_BITS-1:0] bit_cnt;
    logic [LOC_BITS-1:0] k;
    logic [A_BITS-1:0]   p;        // 2^k mod A
    logic                pass2;    // second division after a correction

    logic [A_BITS:0]     rem_shift;
    logic                q_bit;
    logic [A_BITS-1:0]   rem_next;
    logic [A_BITS:0]     p_dbl;
    logic [A_BITS-1:0]   p_next;
    logic [W_BITS:0]     pow_k;
    logic [W_BITS:0]     corr_w;
    logic                hit_pos;
    logic                hit_neg;
    logic                corr_ovf;

    // Divider step, next search candidate and the trial correction
    always_comb begin
        rem_shift = {rem, d_reg[W_BITS-1]};
        q_bit     = (rem_shift >= A_EXT);
        rem_next  = q_bit ? A_BITS'(rem_shift - A_EXT) : rem_shift[A_BITS-1:0];
        p_dbl     = {p, 1'b0};
        p_next    = (p_dbl >= A_EXT) ? A_BITS'(p_dbl - A_EXT) : p_dbl[A_BITS-1:0];
        pow_k     = ONE_W << k;
        hit_pos   = (rem == p);
        hit_neg   = !hit_pos && (rem == (A_VAL - p));
        // e = +2^k is removed by subtracting, e = -2^k by adding
        corr_w    = hit_pos ? ({1'b0, w_reg} - pow_k) : ({1'b0, w_reg} + pow_k);
        corr_ovf  = corr_w[W_BITS];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_DIV;
            S_DIV:   if (bit_cnt == CNT_LAST) state_nxt = S_CHK;
            S_CHK:   state_nxt = (pass2 || rem == '0) ? S_DONE : S_SRCH;
            S_SRCH: begin
                if (hit_pos || hit_neg) state_nxt = corr_ovf ? S_DONE : S_DIV;
                else if (k == K_LAST)   state_nxt = S_DONE;
            end
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Datapath registers and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg         <= '0;
            d_reg         <= '0;
            rem           <= '0;
            bit_cnt       <= '0;
            k             <= '0;
            p             <= '0;
            pass2         <= 1'b0;
            N             <= '0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
            err_neg       <= 1'b0;
            err_loc       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_reg         <= W;
                        d_reg         <= W;
                        rem           <= '0;
                        bit_cnt       <= '0;
                        pass2         <= 1'b0;
                        N             <= '0;
                        corrected     <= 1'b0;
                        uncorrectable <= 1'b0;
                        err_neg       <= 1'b0;
                        err_loc       <= '0;
                    end
                end
                S_DIV: begin
                    rem     <= rem_next;
                    d_reg   <= {d_reg[W_BITS-2:0], q_bit};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_CHK: begin
                    // First-pass quotient is kept as N in case the search gives up
                    N <= d_reg[N_BITS-1:0];
                    if (!pass2 && rem != '0) begin
                        k <= '0;
                        p <= A_BITS'(1);
                    end
                end
                S_SRCH: begin
                    if (hit_pos || hit_neg) begin
                        if (corr_ovf) begin
                            uncorrectable <= 1'b1;
                        end else begin
                            w_reg     <= corr_w[W_BITS-1:0];
                            d_reg     <= corr_w[W_BITS-1:0];
                            rem       <= '0;
                            bit_cnt   <= '0;
                            pass2     <= 1'b1;
                            corrected <= 1'b1;
                            err_neg   <= hit_neg;
                            err_loc   <= k;
                        end
                    end else if (k == K_LAST) begin
                        uncorrectable <= 1'b1;
                    end else begin
                        p <= p_next;
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AN_SEC_STATS_EN
    // Saturating event counters, stepped when a result is handed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (corrected && corr_cnt != 16'hFFFF)       corr_cnt   <= corr_cnt + 16'd1;
            if (uncorrectable && uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_an_sec_decoder_iter.sv
// Bench for an_sec_decoder_iter: directed cases plus random codewords, checked
// every output-valid cycle against a modular-arithmetic model of the decoder.
`timescale 1ns/1ps
module tb_an_sec_decoder_iter;

    localparam int A        = 83;
    localparam int W_BITS   = 36;
    localparam int A_BITS   = 7;
    localparam int N_BITS   = 29;
    localparam int LOC_BITS = 6;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [W_BITS-1:0]   w_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [N_BITS-1:0]   n_out;
    logic                corrected;
    logic                uncorrectable;
    logic                err_neg;
    logic [LOC_BITS-1:0] err_loc;
`ifdef AN_SEC_STATS_EN
    logic [15:0]         corr_cnt;
    logic [15:0]         uncorr_cnt;
`endif

    an_sec_decoder_iter #(
        .A(A), .W_BITS(W_BITS), .A_BITS(A_BITS), .N_BITS(N_BITS), .LOC_BITS(LOC_BITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .W(w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .N(n_out),
        .corrected(corrected),
        .uncorrectable(uncorrectable),
        .err_neg(err_neg),
        .err_loc(err_loc)
`ifdef AN_SEC_STATS_EN
        ,
        .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt)
`endif
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    longint cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [N_BITS-1:0]   n;
        logic                corr;
        logic                unc;
        logic                neg;
        logic [LOC_BITS-1:0] loc;
        int                  lat;
        longint              c0;
    } exp_t;

    exp_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     rdy_mode = 0;      // 0: out_ready high, 1: random, 2: held low
    bit     seen_valid = 1'b0;
    int     exp_corr = 0;
    int     exp_unc = 0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: remainder and quotient by plain division; the error location is the
    // smallest k whose 2^k mod A equals r (positive error) or A-r (negative error).
    function automatic exp_t model(input logic [W_BITS-1:0] w);
        exp_t e;
        longint unsigned wv, r, pw, pk, lim;
        wv = 64'(w);
        r = wv % 64'(A);
        lim = 64'd1 << W_BITS;
        e.n = N_BITS'(wv / 64'(A));
        e.corr = 1'b0; e.unc = 1'b0; e.neg = 1'b0; e.loc = '0;
        e.lat = W_BITS + 2; e.c0 = 0;
        if (r != 0) begin
            e.unc = 1'b1;
            e.lat = 2 * W_BITS + 2;
            for (int k = 0; k < W_BITS; k++) begin
                pw = 64'd1 << k;
                pk = pw % 64'(A);
                if (r == pk || r == 64'(A) - pk) begin
                    if (r == pk ? (wv >= pw) : (wv + pw < lim)) begin
                        e.unc = 1'b0;
                        e.corr = 1'b1;
                        e.neg = (r != pk);
                        e.loc = LOC_BITS'(k);
                        e.n = N_BITS'(((r == pk) ? wv - pw : wv + pw) / 64'(A));
                        e.lat = 2 * W_BITS + k + 4;
                    end else begin
                        e.lat = W_BITS + 3 + k;
                    end
                    break;
                end
            end
        end
        return e;
    endfunction

    // out_ready driver, changes well away from the sampling edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: every output-valid cycle against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef AN_SEC_STATS_EN
            check("corr_cnt", corr_cnt, exp_corr);
            check("uncorr_cnt", uncorr_cnt, exp_unc);
`endif
            if (out_valid && exp_q.size() > 0) begin
                if (!seen_valid) begin
                    check("latency", cycle - exp_q[0].c0 + 1, exp_q[0].lat);
                    seen_valid = 1'b1;
                end
                check("N", n_out, exp_q[0].n);
                check("corrected", corrected, exp_q[0].corr);
                check("uncorrectable", uncorrectable, exp_q[0].unc);
                check("err_neg", err_neg, exp_q[0].neg);
                check("err_loc", err_loc, exp_q[0].loc);
                if (out_ready) begin
                    if (exp_q[0].corr && exp_corr < 65535) exp_corr++;
                    if (exp_q[0].unc && exp_unc < 65535)   exp_unc++;
                    void'(exp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end else if (out_valid) begin
                check("unexpected out_valid", 1, 0);
            end
        end
    end

    // Driver: present one codeword while idle and log its expectation on accept
    task automatic send(input logic [W_BITS-1:0] w);
        exp_t e;
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready timeout", 0, 1);
        end else begin
            w_in = w;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            w_in = {$urandom, $urandom};
            e = model(w);
            e.c0 = cycle;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            check("result timeout", 0, 1);
            exp_q.delete();
            seen_valid = 1'b0;
        end
    endtask

    initial begin
        exp_t m;
        logic [63:0] cw;
        longint unsigned nmax;
        int kind, kk;

        // Model pinned to hand-worked values
        m = model(36'd83000);
        check("model t1 N", m.n, 1000);    check("model t1 lat", m.lat, 38);
        m = model(36'd83008);
        check("model t2 loc", m.loc, 3);   check("model t2 lat", m.lat, 79);
        check("model t2 corr", m.corr, 1);
        m = model(36'd82999);
        check("model t3 neg", m.neg, 1);   check("model t3 lat", m.lat, 76);
        m = model(36'd83070);
        check("model t4 unc", m.unc, 1);   check("model t4 N", m.n, 1000);
        check("model t4 lat", m.lat, 74);
        m = model(36'd5);
        check("model t5 unc", m.unc, 1);   check("model t5 N", m.n, 0);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset N", n_out, 0);
        check("reset corrected", corrected, 0);
        check("reset uncorrectable", uncorrectable, 0);
        check("reset err_loc", err_loc, 0);
        rst_n = 1'b1;

        // Directed cases
        send(36'd83000); wait_done();
        send(36'd83008); wait_done();
        send(36'd82999); wait_done();
        send(36'd83070); wait_done();
        rdy_mode = 2;
        send(36'd5);
        kk = 0;
        while (!out_valid && kk < 200) begin
            @(negedge clk);
            kk++;
        end
        check("t5 out_valid seen", out_valid, 1);
        repeat (10) @(negedge clk);
        rdy_mode = 0;
        wait_done();
`ifdef AN_SEC_STATS_EN
        @(negedge clk);
        check("t2-5 corr_cnt", corr_cnt, 2);
        check("t2-5 uncorr_cnt", uncorr_cnt, 2);
`endif

        // Reset while searching
        send(36'd83070);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        seen_valid = 1'b0;
        exp_corr = 0;
        exp_unc = 0;
        @(negedge clk);
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort N", n_out, 0);
        check("abort uncorrectable", uncorrectable, 0);
        rst_n = 1'b1;
        send(36'd83000); wait_done();

        // Random codewords, single errors of either sign, and raw words
        rdy_mode = 1;
        nmax = ((64'd1 << W_BITS) - 1) / 64'(A);
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            kk = $urandom_range(0, W_BITS - 1);
            cw = 64'(A) * ({$urandom, $urandom} % (nmax + 1));
            case (kind)
                0: ;
                1: cw = cw + (64'd1 << kk);
                2: cw = cw - (64'd1 << kk);
                default: cw = {$urandom, $urandom};
            endcase
            send(cw[W_BITS-1:0]);
            wait_done();
        end
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
